// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store controller between the
// pipeline and a simple req/ready memory port. Byte/halfword/word accesses,
// misalignment rejection, right-justified load data.
// Optional feature: define MEM_TIMEOUT_EN to enable the REQ-state timeout
// counter and Bus_err reporting (TIMEOUT_CYCLES sets the limit).
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Do_load,
  input  logic        Do_store,
  input  logic        Do_Byte,
  input  logic        Do_Half,
  input  logic [31:0] Addr,
  input  logic [31:0] Wdata,
  output logic        Stall,
  output logic [31:0] Rdata_out,
  output logic        Done,
  output logic        Misalign,
  output logic        Bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  // Reject nonsensical timeout limits at elaboration time.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_access_ctrl: TIMEOUT_CYCLES must be within 1..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;
  logic [1:0]  lo_q, lo_d;          // Addr[1:0] of the access in flight
  logic        byte_q, byte_d;
  logic        half_q, half_d;
  logic        stall_c;
  logic        done_c;
`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_err_q, bus_err_d;
`endif

  logic        op;
  logic        misaligned;
  logic [3:0]  be_calc;
  logic [4:0]  rshift;

  // Decode the pipeline request: alignment check and lane enables.
  always_comb begin
    op         = Do_load | Do_store;
    misaligned = 1'b0;
    be_calc    = 4'b1111;
    if (Do_Byte) begin
      be_calc = 4'b0001 << Addr[1:0];
    end else if (Do_Half) begin
      misaligned = Addr[0];
      be_calc    = Addr[1] ? 4'b1100 : 4'b0011;
    end else begin
      misaligned = |Addr[1:0];
    end
  end

  // Right-justify shift for the captured load data, from the latched size/offset.
  always_comb begin
    rshift = 5'd0;
    if (byte_q)      rshift = {lo_q, 3'b000};
    else if (half_q) rshift = {lo_q[1], 4'b0000};
  end

  // Next-state and output logic; unused encodings behave exactly like IDLE.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    lo_d        = lo_q;
    byte_d      = byte_q;
    half_d      = half_q;
    misalign_d  = 1'b0;
    stall_c     = 1'b0;
    done_c      = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d       = cnt_q;
    bus_err_d   = 1'b0;
`endif
    case (state_q)
      REQ: begin
        stall_c = 1'b1;
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
          if (!mem_we_q) rdata_d = mem_rdata >> rshift;
`ifdef MEM_TIMEOUT_EN
        end else if (cnt_q == TIMEOUT_LAST) begin
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = DONE;
          if (!mem_we_q) rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        if (op) begin
          if (misaligned) begin
            misalign_d = 1'b1;
          end else begin
            stall_c     = 1'b1;
            mem_req_d   = 1'b1;
            mem_we_d    = ~Do_load;   // load wins when both are requested
            mem_be_d    = be_calc;
            mem_addr_d  = {Addr[31:2], 2'b00};
            mem_wdata_d = Wdata;
            lo_d        = Addr[1:0];
            byte_d      = Do_Byte;
            half_d      = Do_Half & ~Do_Byte;
            state_d     = REQ;
`ifdef MEM_TIMEOUT_EN
            cnt_d       = 8'd0;
`endif
          end
        end
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      misalign_q  <= 1'b0;
      lo_q        <= 2'd0;
      byte_q      <= 1'b0;
      half_q      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= 8'd0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      misalign_q  <= misalign_d;
      lo_q        <= lo_d;
      byte_q      <= byte_d;
      half_q      <= half_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  // Stall is combinational but forced low while reset is asserted.
  assign Stall     = stall_c & rst_n;
  assign Done      = done_c;
  assign Misalign  = misalign_q;
  assign Rdata_out = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
`ifdef MEM_TIMEOUT_EN
  assign Bus_err   = bus_err_q;
`else
  assign Bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a transaction scoreboard.
// Build with MEM_TIMEOUT_EN defined to also exercise the timeout path.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Do_load = 1'b0, Do_store = 1'b0, Do_Byte = 1'b0, Do_Half = 1'b0;
  logic [31:0] Addr = '0, Wdata = '0, mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        Stall, Done, Misalign, Bus_err, mem_req, mem_we;
  logic [31:0] Rdata_out, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] last_rdata = 32'd0;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .Do_load(Do_load), .Do_store(Do_store), .Do_Byte(Do_Byte), .Do_Half(Do_Half),
    .Addr(Addr), .Wdata(Wdata),
    .Stall(Stall), .Rdata_out(Rdata_out), .Done(Done), .Misalign(Misalign), .Bus_err(Bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] be_model(input logic byt, input logic hf, input logic [1:0] a);
    if (byt) begin
      case (a)
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (hf) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] rd_model(input logic byt, input logic hf,
                                           input logic [1:0] a, input logic [31:0] w);
    if (byt) return w >> (8 * int'(a));
    if (hf)  return w >> (16 * int'(a[1]));
    return w;
  endfunction

  task automatic idle_inputs();
    Do_load = 1'b0; Do_store = 1'b0; Do_Byte = 1'b0; Do_Half = 1'b0; mem_ready = 1'b0;
  endtask

  // One aligned access; memory answers after wait_n non-ready REQ cycles.
  task automatic do_access(input string tag, input logic ld, input logic st,
                           input logic byt, input logic hf, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int wait_n);
    exp_t e;
    int req_cnt = 0, stall_cnt = 0, done_cyc = -1;
    logic berr_at_done = 1'b0;
    e.we = !ld; e.be = be_model(byt, hf, a[1:0]); e.addr = {a[31:2], 2'b00};
    e.wdata = wd; e.rdata = ld ? rd_model(byt, hf, a[1:0], rd) : last_rdata;
    sb.push_back(e);
    @(posedge clk); #1;
    Do_load = ld; Do_store = st; Do_Byte = byt; Do_Half = hf;
    Addr = a; Wdata = wd; mem_rdata = rd; mem_ready = 1'b0;
    for (int c = 0; c < wait_n + 8 && done_cyc < 0; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        mem_ready = 1'b0;
        if (mem_req) begin
          mem_ready = (req_cnt == wait_n);
          req_cnt++;
        end
      end
      @(negedge clk);
      if (Stall) stall_cnt++;
      if (c == 1) chk({tag, ".req_first"}, 32'(mem_req), 32'd1);
      if (mem_req) begin
        chk({tag, ".we"},    32'(mem_we), 32'(sb[0].we));
        chk({tag, ".be"},    32'(mem_be), 32'(sb[0].be));
        chk({tag, ".addr"},  mem_addr,    sb[0].addr);
        chk({tag, ".wdata"}, mem_wdata,   sb[0].wdata);
      end
      if (Done) begin
        done_cyc = c;
        berr_at_done = Bus_err;
      end
    end
    chk({tag, ".done_cycle"}, 32'(done_cyc), 32'(wait_n + 2));
    e = sb.pop_front();
    chk({tag, ".rdata"},  Rdata_out, e.rdata);
    chk({tag, ".stall_cycles"}, 32'(stall_cnt), 32'(wait_n + 2));
    chk({tag, ".bus_err"}, 32'(berr_at_done), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(Done), 32'd0);
    last_rdata = e.rdata;
    $display("txn %s addr=0x%08h be=%b we=%0d rdata_out=0x%08h", tag, a, e.be, e.we, Rdata_out);
  endtask

  // Misaligned request: rejected with a Misalign pulse, no memory traffic.
  task automatic do_misalign(input string tag, input logic hf, input logic [31:0] a);
    @(posedge clk); #1;
    Do_load = 1'b1; Do_Half = hf; Do_Byte = 1'b0; Addr = a;
    @(negedge clk);
    chk({tag, ".stall"}, 32'(Stall), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk({tag, ".misalign"}, 32'(Misalign), 32'd1);
    chk({tag, ".req"}, 32'(mem_req), 32'd0);
    @(negedge clk);
    chk({tag, ".misalign_pulse"}, 32'(Misalign), 32'd0);
    chk({tag, ".req_after"}, 32'(mem_req), 32'd0);
    $display("txn %s addr=0x%08h misalign", tag, a);
  endtask

  initial begin
    // Reset state, with a request present to confirm Stall stays low.
    Do_load = 1'b1; Addr = 32'h0;
    #12;
    chk("rst.stall", 32'(Stall), 32'd0);
    chk("rst.req", 32'(mem_req), 32'd0);
    chk("rst.be", 32'(mem_be), 32'd0);
    chk("rst.rdata", Rdata_out, 32'd0);
    chk("rst.done", 32'(Done), 32'd0);
    chk("rst.misalign", 32'(Misalign), 32'd0);
    idle_inputs();
    @(posedge clk); #1; rst_n = 1'b1;

    do_access("ld_byte_13", 1, 0, 1, 0, 32'h13, 32'h0, 32'hAABBCCDD, 0);
    chk("ld_byte_13.value", Rdata_out, 32'h000000AA);
    do_access("st_half_22", 0, 1, 0, 1, 32'h22, 32'h12341234, 32'hDEADBEEF, 3);
    chk("st_half_22.keep", Rdata_out, 32'h000000AA);
    do_misalign("mis_word_06", 0, 32'h06);
    do_misalign("mis_half_05", 1, 32'h05);
    do_access("ld_st_word_40", 1, 1, 0, 0, 32'h40, 32'h55555555, 32'h01234567, 1);
    for (int i = 0; i < 4; i++)
      do_access("ld_byte_lane", 1, 0, 1, 0, 32'h100 + 32'(i), 32'h0, 32'h8844CC22, i % 3);
    do_access("ld_half_lo", 1, 0, 0, 1, 32'h200, 32'h0, 32'hF00DCAFE, 2);
    do_access("ld_half_hi", 1, 0, 0, 1, 32'h202, 32'h0, 32'hF00DCAFE, 0);
    do_access("st_byte_31", 0, 1, 1, 0, 32'h31, 32'h77777777, 32'h0, 1);
    do_access("byte_wins", 1, 0, 1, 1, 32'h303, 32'h0, 32'h11223344, 0);

    // Reset asserted while a load waits in REQ.
    @(posedge clk); #1;
    Do_load = 1'b1; Addr = 32'h0; mem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid.req_before", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0; #1;
    chk("rst_mid.req", 32'(mem_req), 32'd0);
    chk("rst_mid.stall", 32'(Stall), 32'd0);
    chk("rst_mid.addr", mem_addr, 32'd0);
    chk("rst_mid.rdata", Rdata_out, 32'd0);
    last_rdata = 32'd0;
    idle_inputs();
    @(posedge clk); @(posedge clk); #1; rst_n = 1'b1;
    do_access("ld_after_rst", 1, 0, 0, 0, 32'h0, 32'h0, 32'hCAFEF00D, 1);

`ifdef MEM_TIMEOUT_EN
    // Memory never answers: expect timeout after 4 REQ cycles.
    @(posedge clk); #1;
    Do_load = 1'b1; Addr = 32'h80; mem_ready = 1'b0;
    @(negedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("tmo.req_held", 32'(mem_req), 32'd1);
    end
    @(negedge clk);
    chk("tmo.req_drop", 32'(mem_req), 32'd0);
    chk("tmo.bus_err", 32'(Bus_err), 32'd1);
    chk("tmo.done", 32'(Done), 32'd1);
    chk("tmo.rdata", Rdata_out, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("tmo.bus_err_pulse", 32'(Bus_err), 32'd0);
    $display("txn timeout addr=0x00000080 rdata_out=0x%08h", Rdata_out);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max REQ-state cycles before bus error (used only with MEM_TIMEOUT_EN); range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 Do_load  input  1  pipeline requests load this cycle.
REQ-005 Do_store  input  1  pipeline requests store this cycle.
REQ-006 Do_Byte  input  1  byte access.
REQ-007 Do_Half  input  1  halfword access; word access when Do_Byte and Do_Half are both 0; Do_Byte wins if both are 1.
REQ-008 Addr  input  32  byte address from ALU.
REQ-009 Wdata  input  32  store data, already lane-replicated by the store extender.
REQ-010 Stall  output  1  freeze pipeline; Do_*/Addr/Wdata held stable while high.
REQ-011 Rdata_out  output  32  load data right-justified for the load extender.
REQ-012 Done  output  1  one-cycle pulse when an access completes.
REQ-013 Misalign  output  1  one-cycle pulse on a rejected misaligned access.
REQ-014 Bus_err  output  1  one-cycle pulse on timeout; tied 0 without MEM_TIMEOUT_EN.
REQ-015 mem_req  output  1  memory request, registered.
REQ-016 mem_we  output  1  1 = write, registered.
REQ-017 mem_be  output  4  byte enables, registered.
REQ-018 mem_addr  output  32  word address {Addr[31:2],2'b00}, registered.
REQ-019 mem_wdata  output  32  registered copy of Wdata.
REQ-020 mem_rdata  input  32  memory read word, valid with mem_ready.
REQ-021 mem_ready  input  1  memory completion, sampled only in REQ.

Function
REQ-022 The FSM SHALL have exactly three states, IDLE, REQ and DONE, and SHALL treat any unused encoding as IDLE.
REQ-023 op = Do_load | Do_store; Do_load SHALL take priority when both are 1 (mem_we = 0).
REQ-024 Misaligned access: halfword with Addr[0] = 1, or word with Addr[1:0] != 0.
REQ-025 In IDLE with an aligned op, the block SHALL register addr/be/we/wdata, assert mem_req next cycle and enter REQ; Stall SHALL be high combinationally in that IDLE cycle.
REQ-026 In IDLE with a misaligned op, the block SHALL pulse Misalign next cycle, issue no request, hold Stall low and stay in IDLE.
REQ-027 mem_be: byte = 4'b0001 << Addr[1:0]; half = 4'b0011 << {Addr[1],1'b0}; word = 4'b1111.
REQ-028 In REQ, mem_req and all mem_* outputs SHALL stay stable and Stall SHALL stay high until mem_ready = 1.
REQ-029 On mem_ready = 1 in REQ, the block SHALL drop mem_req next cycle and enter DONE; for a load it SHALL capture Rdata_out = mem_rdata >> (8*Addr[1:0]) for a byte, >> (16*Addr[1]) for a half, and unshifted for a word.
REQ-030 DONE SHALL last one cycle with Done = 1 and Stall = 0, SHALL ignore the inputs and SHALL return to IDLE.
REQ-031 Minimum latency from accepted op to Done SHALL be 2 cycles when mem_ready is 1 on the first REQ cycle.
REQ-032 Rdata_out SHALL hold its value until the next completed load; stores SHALL leave it unchanged.

Reset
REQ-033 While rst_n = 0, including mid-REQ, outputs SHALL immediately be: state IDLE, mem_req = 0, mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0, Rdata_out = 0, Done = Misalign = Bus_err = 0, timeout counter = 0.
REQ-034 Stall SHALL be 0 during reset, and the first op after rst_n rises SHALL be handled from IDLE.

Configuration
REQ-035 With macro MEM_TIMEOUT_EN defined, an 8-bit counter SHALL clear on REQ entry and count each REQ cycle without mem_ready.
REQ-036 With MEM_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL drop mem_req, pulse Bus_err, set Rdata_out = 0 for a load and enter DONE.
REQ-037 Without MEM_TIMEOUT_EN, the counter SHALL be absent, Bus_err SHALL be 0 and REQ SHALL wait indefinitely.

Verification
REQ-038 Load byte, Addr = 0x13, mem_rdata = 0xAABBCCDD, ready on 1st REQ cycle -> mem_be = 4'b1000, mem_addr = 0x10, Rdata_out = 0x000000AA, Done 2 cycles after op.
REQ-039 Store half, Addr = 0x22, Wdata = 0x12341234, ready after 3 wait cycles -> mem_we = 1, mem_be = 4'b1100, Stall high 5 cycles, then one Done pulse.
REQ-040 Load word, Addr = 0x06 -> Misalign pulse, mem_req stays 0, Stall 0; load half at 0x05 -> same result.
REQ-041 Do_load = Do_store = 1, word at 0x40 -> mem_we = 0, read performed.
REQ-042 rst_n low during REQ -> mem_req = 0 immediately; after release, a new load at 0x00 completes normally.
REQ-043 MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4, mem_ready held 0 -> mem_req drops after 4 REQ cycles, Bus_err pulses, Rdata_out = 0, Done pulses.
